// File: rtl/dmem_if.sv
// Store/load port between the core and the data-memory store buffer.
// The core drives the request side; the memory returns load data and status.
interface dmem_if;
    logic        we;
    logic [1:0]  size;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        pending;
    logic        misalign;

    modport master (output we, size, a, wd, input rd, pending, misalign);
    modport slave  (input we, size, a, wd, output rd, pending, misalign);
endinterface

// File: rtl/dmem_store_buffer.sv
// Data memory with a one-entry merging store buffer and overlaid load read-out.
// Optional DMEM_STATS_EN adds saturating commit/merge counters as extra ports.
module dmem_store_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    dmem_if.slave       bus
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] n_commits,
    output logic [15:0] n_merges
`endif
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state, state_nx;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   bidx;
    logic [31:0]     bdata;
    logic [3:0]      bmask;
    logic            misalign_r;

    logic [AW-1:0]   idx;
    logic            legal, st_ok, st_bad, hit;
    logic            do_load, do_merge, do_commit;
    logic [3:0]      lanes;
    logic [31:0]     sdata;
    logic            unused_hi;

    function automatic logic [31:0] lane_merge(input logic [31:0] base,
                                               input logic [31:0] upd,
                                               input logic [3:0]  mask);
        logic [31:0] r;
        r = base;
        for (int k = 0; k < 4; k++)
            if (mask[k]) r[8*k +: 8] = upd[8*k +: 8];
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign idx       = bus.a[AW+1:2];
    assign unused_hi = ^bus.a[31:AW+2];

    // Store decode: data replicated across lanes so the mask alone selects placement.
    always_comb begin
        legal = 1'b0;
        lanes = 4'b0000;
        sdata = 32'h0;
        case (bus.size)
            2'b00: begin
                legal = 1'b1;
                lanes = 4'b0001 << bus.a[1:0];
                sdata = {4{bus.wd[7:0]}};
            end
            2'b01: begin
                legal = ~bus.a[0];
                lanes = bus.a[1] ? 4'b1100 : 4'b0011;
                sdata = {2{bus.wd[15:0]}};
            end
            2'b10: begin
                legal = (bus.a[1:0] == 2'b00);
                lanes = 4'b1111;
                sdata = bus.wd;
            end
            default: ;
        endcase
    end

    assign st_ok  = bus.we & legal;
    assign st_bad = bus.we & ~legal;
    assign hit    = (state == FULL) && (idx == bidx);

    always_comb begin
        state_nx  = state;
        do_load   = 1'b0;
        do_merge  = 1'b0;
        do_commit = 1'b0;
        case (state)
            EMPTY: begin
                if (st_ok) begin
                    do_load  = 1'b1;
                    state_nx = FULL;
                end
            end
            FULL: begin
                if (st_ok && hit) begin
                    do_merge = 1'b1;
                end else if (st_ok) begin
                    do_commit = 1'b1;
                    do_load   = 1'b1;
                end else begin
                    do_commit = 1'b1;
                    state_nx  = EMPTY;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            bmask      <= 4'b0000;
            misalign_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else begin
            state      <= state_nx;
            misalign_r <= st_bad;
            if (do_commit) mem[bidx] <= lane_merge(mem[bidx], bdata, bmask);
            if (do_load)        bmask <= lanes;
            else if (do_merge)  bmask <= bmask | lanes;
        end
    end

    // Buffer payload needs no reset: bmask/state gate every use of it.
    always_ff @(posedge clk) begin
        if (do_load) begin
            bidx  <= idx;
            bdata <= sdata;
        end else if (do_merge) begin
            bdata <= lane_merge(bdata, sdata, lanes);
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            n_commits <= 16'h0;
            n_merges  <= 16'h0;
        end else begin
            if (do_commit) n_commits <= sat_inc(n_commits);
            if (do_merge)  n_merges  <= sat_inc(n_merges);
        end
    end
`endif

    assign bus.rd       = lane_merge(mem[idx], bdata, hit ? bmask : 4'b0000);
    assign bus.pending  = (state == FULL);
    assign bus.misalign = misalign_r;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed cases plus random stores against a
// byte-array model of architectural memory.
module tb_dmem_store_buffer;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    dmem_if bus();
`ifdef DMEM_STATS_EN
    logic [15:0] n_commits, n_merges;
`endif

    dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef DMEM_STATS_EN
        ,
        .n_commits(n_commits),
        .n_merges(n_merges)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] mm [DEPTH*4];
    bit m_pend;
    int unsigned m_pidx;
    int m_commits, m_merges;

    function automatic logic [31:0] mword(input logic [31:0] addr);
        int unsigned w;
        w = (addr >> 2) % DEPTH;
        return {mm[w*4+3], mm[w*4+2], mm[w*4+1], mm[w*4]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts just after a negedge; ends just after the following negedge.
    task automatic step(input logic w, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] data);
        bit lg;
        int unsigned ba, widx;
        bus.we = w; bus.size = sz; bus.a = addr; bus.wd = data;
        #1;
        check("rd_pre", bus.rd, mword(addr));
        lg = (sz == 2'b00) || (sz == 2'b01 && !addr[0]) || (sz == 2'b10 && addr[1:0] == 2'b00);
        @(posedge clk);
        widx = (addr >> 2) % DEPTH;
        ba   = addr % (DEPTH*4);
        if (m_pend && w && lg && widx == m_pidx) m_merges++;
        else if (m_pend) m_commits++;
        if (w && lg) begin
            case (sz)
                2'b00: mm[ba] = data[7:0];
                2'b01: begin mm[ba] = data[7:0]; mm[ba+1] = data[15:8]; end
                default: for (int i = 0; i < 4; i++) mm[ba+i] = data[8*i +: 8];
            endcase
        end
        m_pend = w && lg;
        m_pidx = widx;
        @(negedge clk);
        #1;
        check("pending", {31'b0, bus.pending}, {31'b0, m_pend});
        check("misalign", {31'b0, bus.misalign}, {31'b0, (w && !lg)});
        check("rd_post", bus.rd, mword(addr));
`ifdef DMEM_STATS_EN
        check("n_commits", {16'h0, n_commits}, m_commits);
        check("n_merges", {16'h0, n_merges}, m_merges);
`endif
    endtask

    task automatic peek(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.we = 1'b0; bus.a = addr;
        #1;
        check(tag, bus.rd, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.we = 1'b1; bus.size = 2'b10; bus.a = 32'd84; bus.wd = 32'hDEADBEEF;
        @(posedge clk);
        for (int i = 0; i < DEPTH*4; i++) mm[i] = 8'h00;
        m_pend = 1'b0; m_commits = 0; m_merges = 0;
        @(negedge clk);
        reset = 1'b0;
        bus.we = 1'b0;
        #1;
        check("rst_pending", {31'b0, bus.pending}, 32'd0);
        check("rst_misalign", {31'b0, bus.misalign}, 32'd0);
        check("rst_rd84", bus.rd, 32'h0);
`ifdef DMEM_STATS_EN
        check("rst_commits", {16'h0, n_commits}, 32'd0);
        check("rst_merges", {16'h0, n_merges}, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.we = 1'b0; bus.size = 2'b00; bus.a = 32'h0; bus.wd = 32'h0;
        m_pend = 1'b0; m_pidx = 0; m_commits = 0; m_merges = 0;
        for (int i = 0; i < DEPTH*4; i++) mm[i] = 8'h00;
        @(negedge clk);
        do_reset();

        // Word store then drain.
        step(1'b1, 2'b10, 32'd84, 32'hFFFF0000);
        check("sw_pending", {31'b0, bus.pending}, 32'd1);
        check("sw_rd", bus.rd, 32'hFFFF0000);
        step(1'b0, 2'b00, 32'd84, 32'h0);
        check("drain_pending", {31'b0, bus.pending}, 32'd0);
        check("drain_rd", bus.rd, 32'hFFFF0000);

        // Merge into the pending word.
        do_reset();
        step(1'b1, 2'b10, 32'd84, 32'hFFFF0000);
        step(1'b1, 2'b00, 32'd85, 32'h000000AB);
        check("merge_pending", {31'b0, bus.pending}, 32'd1);
        check("merge_rd", bus.rd, 32'hFFFFAB00);
        step(1'b0, 2'b00, 32'd84, 32'h0);
`ifdef DMEM_STATS_EN
        check("merge_cnt", {16'h0, n_merges}, 32'd1);
        check("commit_cnt", {16'h0, n_commits}, 32'd1);
`endif

        // Back-to-back byte stores to different words.
        do_reset();
        step(1'b1, 2'b00, 32'd84, 32'h11);
        step(1'b1, 2'b00, 32'd88, 32'h22);
        peek("b2b_rd84", 32'd84, 32'h00000011);
        peek("b2b_rd88", 32'd88, 32'h00000022);
        step(1'b0, 2'b00, 32'd84, 32'h0);

        // Misaligned halfword dropped.
        do_reset();
        step(1'b1, 2'b01, 32'd87, 32'hBEEF);
        check("mis_flag", {31'b0, bus.misalign}, 32'd1);
        step(1'b0, 2'b00, 32'd84, 32'h0);
        check("mis_clear", {31'b0, bus.misalign}, 32'd0);
        check("mis_rd", bus.rd, 32'h0);

        // Pending store discarded by reset.
        step(1'b1, 2'b01, 32'd86, 32'hBEEF);
        check("sh_rd", bus.rd, 32'hBEEF0000);
        do_reset();

        // Address aliasing past DEPTH words.
        step(1'b1, 2'b10, 32'd84 + DEPTH*4, 32'h12345678);
        peek("alias_rd84", 32'd84, 32'h12345678);
        step(1'b0, 2'b00, 32'd84, 32'h0);

        // Random traffic over a few words so merges and conflicts are frequent.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 3) != 0),
                     2'($urandom_range(0, 3)),
                     ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 31),
                     $urandom);
            end
        end
        step(1'b0, 2'b00, 32'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
